// File: rtl/fir_decim_avg.sv
// fir_decim_avg
//   Block averager placed after the FIR filter. It averages non-overlapping
//   blocks of N = 2^LOG2_N signed samples and tracks the peak |sample| of
//   each block. One {avg, peak} result per block is presented on a
//   valid/ready port. The input cannot be stalled. A result that arrives
//   while the previous one is still undelivered is dropped, and the sticky
//   overrun flag is set.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous block restart; wins over in_valid
//   in_valid   in_data holds a new sample this cycle
//   in_data    signed sample, DATA_W bits
//   out_valid  result register holds an undelivered result
//   out_ready  consumer takes the result this cycle
//   out_avg    signed block average (floor)
//   out_peak   unsigned peak |sample|, saturated to 2^(DATA_W-1)-1
//   overrun    sticky: a completed result was dropped
module fir_decim_avg #(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [DATA_W-1:0] out_avg,
  output logic        [DATA_W-1:0] out_peak,
  output logic                     overrun
);

  localparam int ACC_W = DATA_W + LOG2_N;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  localparam logic [DATA_W-1:0] ABS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [LOG2_N-1:0] cnt_q, cnt_d;
  logic        [DATA_W-1:0] peak_q, peak_d;
  logic        [0:0]        state_q, state_d;
  logic        [DATA_W-1:0] avg_q, avg_d;
  logic        [DATA_W-1:0] opk_q, opk_d;
  logic                     ovr_q, ovr_d;

  // Datapath helpers
  logic                     take;
  logic                     done;
  logic        [DATA_W-1:0] abs_v;
  logic        [DATA_W-1:0] pk_new;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  sum_shr;

  assign take = in_valid && !clear;
  // The count wraps at all-ones, so cnt == '1 marks the Nth sample.
  assign done = take && (cnt_q == {LOG2_N{1'b1}});

  // The most negative code has no positive twin, so it saturates.
  always_comb begin
    abs_v = in_data;
    if (in_data == NEG_MIN)
      abs_v = ABS_MAX;
    else if (in_data[DATA_W-1])
      abs_v = -in_data;
  end

  assign pk_new  = (abs_v > peak_q) ? abs_v : peak_q;
  assign sum     = acc_q + {{LOG2_N{in_data[DATA_W-1]}}, in_data};
  // An arithmetic shift gives a floor toward -inf. The result always fits
  // in DATA_W bits because |sum| <= N * 2^(DATA_W-1).
  assign sum_shr = sum >>> LOG2_N;

  // Accumulator, count and peak
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    peak_d = peak_q;
    if (clear) begin
      acc_d  = '0;
      cnt_d  = '0;
      peak_d = '0;
    end else if (take) begin
      if (done) begin
        // Restart in the same edge, so the next cycle's sample opens
        // the new block.
        acc_d  = '0;
        cnt_d  = '0;
        peak_d = '0;
      end else begin
        acc_d  = sum;
        cnt_d  = cnt_q + 1'b1;
        peak_d = pk_new;
      end
    end
  end

  // Output register FSM
  always_comb begin
    state_d = state_q;
    avg_d   = avg_q;
    opk_d   = opk_q;
    ovr_d   = ovr_q;
    if (clear) begin
      // The data registers keep their last values; only the flags drop.
      state_d = EMPTY;
      ovr_d   = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (done) begin
            state_d = FULL;
            avg_d   = sum_shr[DATA_W-1:0];
            opk_d   = pk_new;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (done) begin
              avg_d = sum_shr[DATA_W-1:0];
              opk_d = pk_new;
            end else begin
              state_d = EMPTY;
            end
          end else if (done) begin
            // The consumer still holds the old result; drop the new one.
            ovr_d = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      peak_q  <= '0;
      state_q <= EMPTY;
      avg_q   <= '0;
      opk_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
      state_q <= state_d;
      avg_q   <= avg_d;
      opk_q   <= opk_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_avg   = avg_q;
  assign out_peak  = opk_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_fir_decim_avg.sv
// Directed bench for fir_decim_avg (DATA_W=8, LOG2_N=2).
module tb_fir_decim_avg;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic signed [7:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic       [7:0] out_avg;
  logic       [7:0] out_peak;
  logic             overrun;

  int checks = 0;
  int errors = 0;

  fir_decim_avg #(.DATA_W(8), .LOG2_N(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_avg   (out_avg),
    .out_peak  (out_peak),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample for one clock; returns 1 time unit after the edge.
  task automatic smp(input logic signed [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12 rst_n = 1'b1;
    idle(1);
    chk("rst_valid", out_valid, 0);
    chk("rst_avg", out_avg, 0);
    chk("rst_peak", out_peak, 0);
    chk("rst_ovr", overrun, 0);

    // Back-to-back 10,20,30,40
    smp(8'sd10); smp(8'sd20); smp(8'sd30);
    chk("b2b_novalid", out_valid, 0);
    smp(8'sd40);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_avg", out_avg, 8'd25);
    chk("b2b_peak", out_peak, 8'd40);
    idle(1);
    chk("b2b_drop", out_valid, 0);

    // -1,-1,-1,-2 with gaps -> floor(-5/4) = -2
    smp(-8'sd1); idle(1); smp(-8'sd1); idle(1); smp(-8'sd1); idle(1);
    chk("neg_novalid", out_valid, 0);
    smp(-8'sd2);
    chk("neg_valid", out_valid, 1);
    chk("neg_avg", out_avg, 8'hFE);
    chk("neg_peak", out_peak, 8'd2);
    idle(1);

    // Extremes
    for (int i = 0; i < 4; i++) smp(-8'sd128);
    chk("min_valid", out_valid, 1);
    chk("min_avg", out_avg, 8'h80);
    chk("min_peak", out_peak, 8'd127);
    for (int i = 0; i < 4; i++) smp(8'sd127);
    chk("max_valid", out_valid, 1);
    chk("max_avg", out_avg, 8'd127);
    chk("max_peak", out_peak, 8'd127);
    idle(1);

    // Overrun: two blocks with no consumer
    out_ready = 1'b0;
    smp(8'sd4); smp(8'sd4); smp(8'sd6); smp(8'sd6);
    chk("ovr_b1_avg", out_avg, 8'd5);
    chk("ovr_b1_ovr", overrun, 0);
    smp(8'sd8); smp(8'sd8); smp(8'sd10); smp(8'sd10);
    chk("ovr_b2_valid", out_valid, 1);
    chk("ovr_b2_avg", out_avg, 8'd5);
    chk("ovr_b2_peak", out_peak, 8'd6);
    chk("ovr_b2_ovr", overrun, 1);
    out_ready = 1'b1;
    idle(1);
    chk("ovr_drain", out_valid, 0);
    chk("ovr_sticky", overrun, 1);
    pulse_clear();
    chk("ovr_clear", overrun, 0);

    // Ready arrives exactly on the completing cycle of block 2
    out_ready = 1'b0;
    smp(8'sd4); smp(8'sd4); smp(8'sd6); smp(8'sd6);
    smp(8'sd8); smp(8'sd8); smp(8'sd10);
    out_ready = 1'b1;
    smp(8'sd10);
    chk("rdy_valid", out_valid, 1);
    chk("rdy_avg", out_avg, 8'd9);
    chk("rdy_peak", out_peak, 8'd10);
    chk("rdy_ovr", overrun, 0);

    // Asynchronous reset mid-block
    smp(8'sd50); smp(8'sd50);
    #3 rst_n = 1'b0;
    #2;
    chk("arst_valid", out_valid, 0);
    chk("arst_avg", out_avg, 0);
    chk("arst_peak", out_peak, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    smp(8'sd4); smp(8'sd4);
    chk("arst_partial", out_valid, 0);
    smp(8'sd4); smp(8'sd4);
    chk("arst_blk_valid", out_valid, 1);
    chk("arst_blk_avg", out_avg, 8'd4);

    // clear with a concurrent sample, mid-block
    smp(8'sd50); smp(8'sd50);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'sd100;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0; in_data = '0;
    chk("clr_valid", out_valid, 0);
    chk("clr_avg_hold", out_avg, 8'd4);
    smp(8'sd4); smp(8'sd4); smp(8'sd4);
    chk("clr_partial", out_valid, 0);
    smp(8'sd4);
    chk("clr_blk_valid", out_valid, 1);
    chk("clr_blk_avg", out_avg, 8'd4);
    chk("clr_blk_peak", out_peak, 8'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_decim_avg.md
Name: fir_decim_avg

Overview:
- Downstream stage of the FIR filter: consumes the filter's signed 8-bit output samples and averages non-overlapping blocks of N = 2^LOG2_N samples.
- Per block it also tracks the peak absolute value.
- Presents one {average, peak} result per block through a valid/ready output port, for the host readout / output mux.
- The FIR cannot be stalled, so the input has no backpressure. A result that cannot be delivered is dropped and flagged with a sticky overrun bit.

Parameters:
- DATA_W, 8: sample width, signed two's complement; in_data, out_avg and out_peak all use this width.
- LOG2_N, 2: log2 of block length; N = 2^LOG2_N; legal range 1..6.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- clear, input, 1: synchronous block restart, active high.
- in_valid, input, 1: in_data carries a new FIR sample this cycle.
- in_data, input, DATA_W: signed FIR output sample.
- out_valid, output, 1: result register holds an undelivered result.
- out_ready, input, 1: consumer accepts the result this cycle.
- out_avg, output, DATA_W: signed block average.
- out_peak, output, DATA_W: unsigned peak |sample| of block, saturated to 2^(DATA_W-1)-1.
- overrun, output, 1: sticky flag, a result was dropped.

Behaviour:
- Reset (rst_n low, asynchronous): acc, cnt, peak, out_avg, out_peak, out_valid and overrun all become 0. This applies mid-block too; the partial block is discarded.
- Internal state:
  - acc: signed accumulator, DATA_W+LOG2_N bits; cannot overflow.
  - cnt: LOG2_N-bit sample counter.
  - peak: DATA_W bits.
- Sample accept (in_valid=1, clear=0):
  - acc += sign-extended in_data.
  - peak = max(peak, absval(in_data)), where absval(-2^(DATA_W-1)) saturates to 2^(DATA_W-1)-1.
  - cnt increments.
- in_valid gaps of any length are allowed; state holds while in_valid=0.
- Block completion, on the accepted sample where cnt == N-1:
  - sum = acc + in_data.
  - avg = sum arithmetically shifted right by LOG2_N (floor toward -inf).
  - pk = max(peak, absval(in_data)).
  - acc, cnt and peak return to 0 in the same edge, so the next cycle's sample starts the new block with no gap cycle.
- Output register, two-state FSM:
  - EMPTY (out_valid=0) -> FULL when a block completes: out_avg/out_peak load; out_valid=1 on the edge after the Nth sample (latency 1 cycle).
  - FULL, out_ready=1, no completion -> EMPTY; out_avg/out_peak hold their last value.
  - FULL, out_ready=1, completion in the same cycle -> stays FULL with the new result loaded; no overrun.
  - FULL, out_ready=0, completion -> new result dropped, old result retained unchanged, overrun set to 1.
  - FULL, out_ready=0, no completion -> hold.
- out_avg/out_peak only change on a load; they are stable while out_valid=1 and out_ready=0.
- overrun is sticky; cleared only by rst_n or clear.
- clear=1 takes priority over in_valid in the same cycle:
  - acc, cnt, peak, out_valid and overrun go to 0; the sample is ignored.
  - out_avg/out_peak keep their values.
- out_ready while EMPTY is ignored.
- Purely synchronous datapath; no combinational path from in_* to out_*.

Test Plan (defaults: DATA_W=8, N=4):
- Back-to-back samples 10,20,30,40 on consecutive cycles, out_ready=1 -> one cycle after 40: out_valid=1, out_avg=25, out_peak=40; out_valid drops next cycle.
- Samples -1,-1,-1,-2 with an idle cycle between each -> sum -5, out_avg=-2 (0xFE, floor), out_peak=2; no result before the 4th sample.
- Four samples of -128 -> out_avg=-128 (0x80), out_peak=127. Then 127 x4 -> out_avg=127, out_peak=127.
- out_ready=0, eight samples (blocks avg 5 then avg 9):
  - out_avg stays 5 and overrun=1 after the second block.
  - Then out_ready=1 -> out_valid drops; overrun remains 1 until clear pulses, then reads 0.
- out_ready=1 asserted exactly in the cycle block 2 completes while block 1 is FULL -> block 2 result loaded, out_valid stays 1, overrun=0.
- Reset and clear mid-block:
  - After 2 samples (50,50), pulse rst_n low asynchronously (not clock-aligned) -> all outputs 0 immediately; next samples 4,4,4,4 -> out_avg=4, not polluted by 50s.
  - Repeat the sequence with clear plus a concurrent in_valid -> same result; the concurrent sample is ignored.
